// File: rtl/ir_fetch_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ir_fetch_sequencer_pkg
//   Shared control definitions for the instruction fetch path: the fetch
//   sequencer state encoding and the IR half-select codes used by the
//   sequencer, the IR and the decoder.
// ---------------------------------------------------------------------------
package ir_fetch_sequencer_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      REQ_A  = 3'd1,
      LOAD_A = 3'd2,
      REQ_B  = 3'd3,
      LOAD_B = 3'd4,
      DONE   = 3'd5,
      ERR    = 3'd6
   } fetch_state_t;

   localparam logic IR_HALF_LO = 1'b0;
   localparam logic IR_HALF_HI = 1'b1;

endpackage

// File: rtl/ir_fetch_sequencer_ack_timeout_counter.sv
// ---------------------------------------------------------------------------
// ack_timeout_counter
//   Counts cycles spent waiting for a memory ack.
//   clk, rst  : clock, async active-low reset
//   clr       : clear to zero (has priority over inc)
//   inc       : advance by one
//   expired   : counter sits on the last allowed wait cycle
//   ACK_TIMEOUT = 0 disables counting; expired never rises.
// ---------------------------------------------------------------------------
module ack_timeout_counter #(
   parameter int ACK_TIMEOUT = 15,
   parameter int TO_W        = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam bit            EN    = (ACK_TIMEOUT > 0);
   localparam logic [TO_W-1:0] LIMIT = EN ? TO_W'(ACK_TIMEOUT - 1) : '0;

   logic [TO_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)            cnt <= '0;
      else if (clr)        cnt <= '0;
      else if (inc && EN)  cnt <= cnt + 1'b1;
   end

   assign expired = EN && (cnt == LIMIT);

endmodule

// File: rtl/ir_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// ir_fetch_sequencer
//   Fetches a 16-bit instruction as two byte reads and loads it into the IR
//   one half at a time.
//   clk, rst        : clock, async active-low reset
//   fetch_req       : start a fetch (level, sampled in IDLE and DONE)
//   flush           : abort; gates all strobes this cycle, IDLE next
//   mem_ack/rdata   : memory byte response
//   mem_rd          : memory read request, held until ack
//   ir_data         : latched byte for the IR byte input
//   ir_write/ir_lh  : IR write strobe and half select (1 = high)
//   pc_inc          : PC increment strobe, one per byte loaded
//   busy/done/fetch_err : status; done and fetch_err are one-cycle pulses
// ---------------------------------------------------------------------------
module ir_fetch_sequencer
   import ir_fetch_sequencer_pkg::*;
#(
   parameter bit HI_FIRST    = 1'b0,
   parameter int ACK_TIMEOUT = 15,
   parameter int TO_W        = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       fetch_req,
   input  logic       flush,
   input  logic       mem_ack,
   input  logic [7:0] mem_rdata,
   output logic       mem_rd,
   output logic [7:0] ir_data,
   output logic       ir_write,
   output logic       ir_lh,
   output logic       pc_inc,
   output logic       busy,
   output logic       done,
   output logic       fetch_err
);

   localparam logic HALF_A = HI_FIRST ? IR_HALF_HI : IR_HALF_LO;
   localparam logic HALF_B = HI_FIRST ? IR_HALF_LO : IR_HALF_HI;

   fetch_state_t state;
   logic         in_req, in_load, to_exp;

   assign in_req  = (state == REQ_A)  || (state == REQ_B);
   assign in_load = (state == LOAD_A) || (state == LOAD_B);

   // Counter only runs while a request is outstanding and unanswered.
   ack_timeout_counter #(
      .ACK_TIMEOUT(ACK_TIMEOUT),
      .TO_W       (TO_W)
   ) u_to (
      .clk    (clk),
      .rst    (rst),
      .clr    (flush | ~in_req | mem_ack),
      .inc    (in_req & ~mem_ack),
      .expired(to_exp)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         ir_data <= '0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE:   if (fetch_req) state <= REQ_A;
            REQ_A: begin
               // An ack on the expiry cycle still wins.
               if (mem_ack) begin
                  ir_data <= mem_rdata;
                  state   <= LOAD_A;
               end else if (to_exp) begin
                  state <= ERR;
               end
            end
            LOAD_A: state <= REQ_B;
            REQ_B: begin
               if (mem_ack) begin
                  ir_data <= mem_rdata;
                  state   <= LOAD_B;
               end else if (to_exp) begin
                  state <= ERR;
               end
            end
            LOAD_B: state <= DONE;
            DONE:   state <= fetch_req ? REQ_A : IDLE;
            ERR:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Moore decode, with flush gating the strobes in its own cycle.
   assign mem_rd    = in_req  & ~flush;
   assign ir_write  = in_load & ~flush;
   assign pc_inc    = in_load & ~flush;
   assign ir_lh     = ir_write & ((state == LOAD_A) ? HALF_A : HALF_B);
   assign done      = (state == DONE) & ~flush;
   assign fetch_err = (state == ERR)  & ~flush;
   assign busy      = (state != IDLE);

endmodule

// File: doc/ir_fetch_sequencer.md
Name: ir_fetch_sequencer

Overview:
Sequences a 16-bit instruction fetch from byte-wide memory into the instruction register (IR). The IR is loaded one byte per write, with a select line choosing the high or low half. On a fetch request the block performs two memory byte reads with a req/ack handshake. It latches each returned byte and drives the IR write/half-select and PC-increment strobes. It signals completion to the control unit and supports flush and ack-timeout.

Parameters:
HI_FIRST, 0, 0: byte at PC loads IR[7:0] and PC+1 loads IR[15:8]; 1: reversed order.
ACK_TIMEOUT, 15, max cycles waiting for mem_ack per byte; 0 disables the timeout.
TO_W, 4, timeout counter width; must hold ACK_TIMEOUT.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
fetch_req  in  1  start a fetch; level, sampled in IDLE and DONE
flush  in  1  abort any in-progress fetch
mem_ack  in  1  mem_rdata valid this cycle
mem_rdata  in  8  memory read byte
mem_rd  out  1  memory read request, held until ack
ir_data  out  8  latched byte to IR byte input
ir_write  out  1  IR write strobe
ir_lh  out  1  IR half select: 1 = high byte, 0 = low byte
pc_inc  out  1  one-cycle PC increment strobe
busy  out  1  state != IDLE
done  out  1  one-cycle pulse, both bytes written
fetch_err  out  1  one-cycle pulse, ack timeout

Behaviour:
- Reset (rst=0, async): state IDLE; ir_data=0; timeout counter=0; all strobes and done/fetch_err/busy = 0.
- States: IDLE, REQ_A, LOAD_A, REQ_B, LOAD_B, DONE, ERR. Outputs are decoded from state (Moore); ir_data is a register.
- IDLE: fetch_req=1 -> REQ_A.
- REQ_A / REQ_B:
  - mem_rd=1.
  - On mem_ack: ir_data<=mem_rdata, counter cleared, go to LOAD_A / LOAD_B.
  - Otherwise counter increments.
- LOAD_A: ir_write=1, pc_inc=1, ir_lh=HI_FIRST -> REQ_B.
- LOAD_B: ir_write=1, pc_inc=1, ir_lh=~HI_FIRST -> DONE.
- DONE: done=1. If fetch_req=1 -> REQ_A (back-to-back fetch, no IDLE bubble); else -> IDLE.
- ERR: fetch_err=1 -> IDLE. The IR keeps any half already written; PC is not rolled back.
- Timeout: with ACK_TIMEOUT>0, when the counter equals ACK_TIMEOUT-1 in a REQ state and mem_ack=0 -> ERR. mem_rd is therefore high for exactly ACK_TIMEOUT cycles. An ack on that same cycle wins and proceeds normally.
- ir_lh is don't-care when ir_write=0; drive it 0.
- Latency, zero-wait memory (ack on the first mem_rd cycle), measured from the fetch_req edge: REQ_A at +1, LOAD_A +2, REQ_B +3, LOAD_B +4, done at +5. Each extra wait cycle adds 1.
- flush:
  - Highest priority; next state is IDLE from any state.
  - In the same cycle ir_write, pc_inc, mem_rd, done and fetch_err are forced to 0 (combinational gating).
  - flush together with fetch_req in IDLE -> stays IDLE.
- mem_ack outside REQ states is ignored; ir_data is unchanged.
- fetch_req deasserting mid-fetch has no effect; the fetch completes.
- Async reset mid-fetch: immediate return to reset values; no partial strobes.

Decomposition:
- Shared control package:
  - state encoding enum (3-bit): IDLE=0, REQ_A=1, LOAD_A=2, REQ_B=3, LOAD_B=4, DONE=5, ERR=6
  - constants IR_HALF_LO=0, IR_HALF_HI=1, shared with the IR and decoder
- One natural sub-module, ack_timeout_counter: clear, increment, enable parameter and expired flag. Everything else stays in a single FSM module.

Test Plan:
- Zero-wait fetch, HI_FIRST=0: fetch_req pulse at cycle 0, ack same cycle as each mem_rd with bytes 0x34 then 0x12 -> ir_write with ir_lh=0, ir_data=0x34 at cycle 2; ir_lh=1, ir_data=0x12 at cycle 4; pc_inc at 2 and 4; done at 5; IR model=0x1234.
- Wait states: ack delayed 3 cycles per byte -> mem_rd high 4 cycles per byte, done at cycle 11, exactly two pc_inc; HI_FIRST=1 run loads 0x12 high first.
- Back-to-back: fetch_req held high for two fetches -> DONE goes directly to REQ_A; second fetch writes 0xBEEF; two done pulses 5 cycles apart; 4 pc_inc total.
- Timeout: ACK_TIMEOUT=15, no ack on byte B -> mem_rd high 15 cycles, fetch_err pulse, IDLE, busy=0; only one ir_write/pc_inc occurred.
- Flush: assert flush in LOAD_A cycle -> no ir_write or pc_inc that cycle, IDLE next; flush+fetch_req in IDLE -> stays IDLE.
- Reset: drive rst=0 mid-REQ_B asynchronously -> all outputs 0 before next clk edge; state IDLE; ir_data=0.
